// File: rtl/stream_packer_32to64_pkg.sv
// Shared constants, FSM encoding and byte-swap helper for the 32->64 stream packer.
package stream_packer_32to64_pkg;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_CNT_W      = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOW   = 2'd1,
      ST_HIGH  = 2'd2,
      ST_DRAIN = 2'd3
   } pk_state_t;

   // Output byte k takes packed byte 7-k (host little-endian -> core big-endian).
   function automatic logic [63:0] swap_bytes64(input logic [63:0] p);
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r[8*k +: 8] = p[8*(7-k) +: 8];
      return r;
   endfunction
endpackage

// File: rtl/stream_packer_32to64_fifo.sv
// 64-bit FIFO whose head word is held in a register, so a word pushed into an
// empty FIFO is visible on the output in the very next cycle.
module stream_fifo64
   import stream_packer_32to64_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_push,
   input  logic [63:0] i_data,
   input  logic        i_pop,
   output logic        o_full,
   output logic        o_empty,
   output logic [63:0] o_head,
   output logic        o_head_vld
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [63:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [CW-1:0] r_cnt;
   logic [63:0]   r_head;
   logic          r_head_vld;

   logic          w_push, w_pop;
   logic [AW-1:0] w_rd_nxt;
   logic [CW-1:0] w_cnt_pop, w_cnt_nxt;

   assign o_full     = (r_cnt == CW'(DEPTH));
   assign o_empty    = (r_cnt == '0);
   assign o_head     = r_head;
   assign o_head_vld = r_head_vld;

   assign w_push    = i_push && !o_full;
   assign w_pop     = i_pop && r_head_vld;
   assign w_rd_nxt  = r_rd + AW'(w_pop);
   assign w_cnt_pop = r_cnt - CW'(w_pop);
   assign w_cnt_nxt = w_cnt_pop + CW'(w_push);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

   // Head comes from storage if anything survives the pop, else from the incoming word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr       <= '0;
         r_rd       <= '0;
         r_cnt      <= '0;
         r_head     <= '0;
         r_head_vld <= 1'b0;
      end else begin
         r_wr       <= r_wr + AW'(w_push);
         r_rd       <= w_rd_nxt;
         r_cnt      <= w_cnt_nxt;
         r_head_vld <= (w_cnt_nxt != '0);
         if (w_cnt_pop != '0) r_head <= r_mem[w_rd_nxt];
         else if (w_push)     r_head <= i_data;
         else                 r_head <= '0;
      end
   end
endmodule

// File: rtl/stream_packer_32to64.sv
// Packs pairs of 32-bit host half-words into byte-swapped 64-bit words, framed
// by a word count, and buffers them in a small output FIFO.
module stream_packer_32to64
   import stream_packer_32to64_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] len,
   input  logic             len_isReady,
   output logic             len_canReceive,
   input  logic [31:0]      in,
   input  logic             in_isReady,
   output logic             in_canReceive,
   output logic [63:0]      out,
   output logic             out_isReady,
   input  logic             out_canReceive,
   output logic             busy,
   output logic             done
);
   pk_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_lo;
   logic             r_done;

   logic w_full, w_empty, w_len_acc, w_in_acc, w_push;

   assign len_canReceive = (r_state == ST_IDLE);
   assign in_canReceive  = ((r_state == ST_LOW) || (r_state == ST_HIGH)) && !w_full;
   assign busy           = (r_state != ST_IDLE);
   assign done           = r_done;

   assign w_len_acc = len_isReady && len_canReceive;
   assign w_in_acc  = in_isReady && in_canReceive;
   assign w_push    = w_in_acc && (r_state == ST_HIGH);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: if (w_len_acc) begin
               if (len == '0) r_done <= 1'b1;
               else begin
                  r_cnt   <= len;
                  r_state <= ST_LOW;
               end
            end
            ST_LOW: if (w_in_acc) begin
               r_lo    <= in;
               r_state <= ST_HIGH;
            end
            ST_HIGH: if (w_in_acc) begin
               r_cnt   <= r_cnt - CNT_W'(1);
               r_state <= (r_cnt == CNT_W'(1)) ? ST_DRAIN : ST_LOW;
            end
            ST_DRAIN: if (w_empty) begin
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   stream_fifo64 #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_push),
      .i_data    (swap_bytes64({in, r_lo})),
      .i_pop     (out_canReceive),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_head    (out),
      .o_head_vld(out_isReady)
   );
endmodule

// File: tb/tb_stream_packer_32to64.sv
// Randomized bench for stream_packer_32to64 against a queue-based frame model,
// plus directed frames with literal expectations.
module tb_stream_packer_32to64;
   localparam int DEPTH = 4;
   localparam int CW    = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] len;
   logic          len_isReady, len_canReceive;
   logic [31:0]   in;
   logic          in_isReady, in_canReceive;
   logic [63:0]   out;
   logic          out_isReady, out_canReceive;
   logic          busy, done;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stream_packer_32to64 #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .len(len), .len_isReady(len_isReady), .len_canReceive(len_canReceive),
      .in(in), .in_isReady(in_isReady), .in_canReceive(in_canReceive),
      .out(out), .out_isReady(out_isReady), .out_canReceive(out_canReceive),
      .busy(busy), .done(done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Build the output word byte by byte from P = {hi, lo}.
   function automatic logic [63:0] swap_ref(input logic [31:0] hi, input logic [31:0] lo);
      logic [63:0] p, r;
      p = {hi, lo};
      r = 64'd0;
      for (int k = 0; k < 8; k++) r = r | (((p >> (8 * (7 - k))) & 64'hFF) << (8 * k));
      return r;
   endfunction

   // Frame model: halves still owed, pending lo half, queue of words not yet taken.
   bit          m_busy, m_done, m_phase, m_acc_in, m_acc_len;
   int          m_halves;
   logic [31:0] m_lo;
   logic [63:0] m_q[$];
   int          dut_pops = 0;

   bit exp_in_cr, acc_len, acc_in, pop, drain_done, nd;

   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_out", out, 64'd0);
         chk("rst_out_isReady", {63'd0, out_isReady}, 64'd0);
         chk("rst_in_canReceive", {63'd0, in_canReceive}, 64'd0);
         chk("rst_busy", {63'd0, busy}, 64'd0);
         chk("rst_done", {63'd0, done}, 64'd0);
         m_busy = 0; m_done = 0; m_phase = 0; m_halves = 0; m_lo = '0;
         m_acc_in = 0; m_acc_len = 0;
         m_q.delete();
      end else begin
         exp_in_cr = m_busy && (m_halves > 0) && (m_q.size() < DEPTH);
         chk("in_canReceive", {63'd0, in_canReceive}, {63'd0, exp_in_cr});
         chk("len_canReceive", {63'd0, len_canReceive}, {63'd0, !m_busy});
         chk("busy", {63'd0, busy}, {63'd0, m_busy});
         chk("done", {63'd0, done}, {63'd0, m_done});
         chk("out_isReady", {63'd0, out_isReady}, {63'd0, m_q.size() > 0});
         chk("out", out, (m_q.size() > 0) ? m_q[0] : 64'd0);
         if (out_isReady && out_canReceive) dut_pops++;

         acc_len    = len_isReady && !m_busy;
         acc_in     = in_isReady && exp_in_cr;
         pop        = (m_q.size() > 0) && out_canReceive;
         drain_done = m_busy && (m_halves == 0) && (m_q.size() == 0);
         nd         = 0;
         if (pop) void'(m_q.pop_front());
         if (acc_in) begin
            if (!m_phase) m_lo = in;
            else m_q.push_back(swap_ref(in, m_lo));
            m_phase  = !m_phase;
            m_halves = m_halves - 1;
         end
         if (acc_len) begin
            if (len == 0) nd = 1;
            else begin
               m_busy = 1; m_halves = 2 * int'(len); m_phase = 0;
            end
         end
         if (drain_done) begin
            nd = 1; m_busy = 0;
         end
         m_done    = nd;
         m_acc_in  = acc_in;
         m_acc_len = acc_len;
      end
   end

   // All driver tasks start and end one time unit after a rising edge.
   task automatic start_frame(input int n);
      int t;
      t = 0;
      len = CW'(n); len_isReady = 1'b1;
      do begin
         @(posedge clk); #1; t++;
      end while (!m_acc_len && t < 50);
      if (!m_acc_len) chk("len_accept_timeout", 64'd0, 64'd1);
      len_isReady = 1'b0;
   endtask

   task automatic send_halves(input int k, input int in_pct, input int out_pct, output int stalls);
      int got, t;
      got = 0; t = 0; stalls = 0;
      while (got < k && t < 30000) begin
         in             = $urandom;
         in_isReady     = ($urandom_range(0, 99) < in_pct);
         out_canReceive = ($urandom_range(0, 99) < out_pct);
         @(posedge clk); #1; t++;
         if (m_acc_in) got++;
         else if (in_isReady) stalls++;
      end
      in_isReady = 1'b0;
      if (got < k) chk("send_timeout", 64'(got), 64'(k));
   endtask

   task automatic finish_frame(input int out_pct);
      int t;
      t = 0;
      while (!m_done && t < 2000) begin
         out_canReceive = ($urandom_range(0, 99) < out_pct);
         @(posedge clk); #1; t++;
      end
      if (!m_done) chk("done_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int st, pops0, n;
      rst = 1'b1; len = '0; len_isReady = 1'b0; in = '0; in_isReady = 1'b0;
      out_canReceive = 1'b0;
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      chk("post_rst_len_canReceive", {63'd0, len_canReceive}, 64'd1);

      // len=1 directed word
      start_frame(1);
      out_canReceive = 1'b1;
      in = 32'h03020100; in_isReady = 1'b1;
      @(posedge clk); #1;
      in = 32'h07060504;
      @(posedge clk); #1;
      in_isReady = 1'b0;
      chk("req036_out", out, 64'h0001020304050607);
      chk("req036_out_isReady", {63'd0, out_isReady}, 64'd1);
      @(posedge clk); #1;
      chk("req036_popped", {63'd0, out_isReady}, 64'd0);
      @(posedge clk); #1;
      chk("req036_done", {63'd0, done}, 64'd1);
      chk("req036_busy", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      chk("req036_done_pulse", {63'd0, done}, 64'd0);

      // len=0
      start_frame(0);
      chk("req038_done", {63'd0, done}, 64'd1);
      chk("req038_out_isReady", {63'd0, out_isReady}, 64'd0);
      @(posedge clk); #1;
      chk("req038_done_pulse", {63'd0, done}, 64'd0);
      chk("req038_busy", {63'd0, busy}, 64'd0);

      // len=6 with the sink stalled until the FIFO fills
      start_frame(6);
      send_halves(8, 100, 0, st);
      repeat (3) begin
         chk("req037_full_stall", {63'd0, in_canReceive}, 64'd0);
         @(posedge clk); #1;
      end
      send_halves(4, 100, 100, st);
      finish_frame(100);

      // reset mid-frame, then a clean len=1 frame
      start_frame(3);
      send_halves(3, 100, 0, st);
      chk("req039_pre_rst_vld", {63'd0, out_isReady}, 64'd1);
      rst = 1'b0;
      #1;
      chk("req039_out", out, 64'd0);
      chk("req039_out_isReady", {63'd0, out_isReady}, 64'd0);
      chk("req039_in_canReceive", {63'd0, in_canReceive}, 64'd0);
      chk("req039_busy", {63'd0, busy}, 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      start_frame(1);
      send_halves(2, 100, 100, st);
      finish_frame(100);

      // continuous flow: no stalls expected
      start_frame(8);
      send_halves(16, 100, 100, st);
      chk("req041_stalls", 64'(st), 64'd0);
      finish_frame(100);

      // short random frames
      repeat (6) begin
         n = $urandom_range(1, 9);
         start_frame(n);
         send_halves(2 * n, 60, 50, st);
         finish_frame(50);
      end

      // long frame with random stalls
      pops0 = dut_pops;
      start_frame(2688);
      send_halves(2 * 2688, 70, 60, st);
      finish_frame(60);
      chk("req040_words", 64'(dut_pops - pops0), 64'd2688);
      chk("req040_model_empty", 64'(m_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
